// File: rtl/uart_cmd_parser_if.sv
// Byte-stream / config-write bundle between the UART receiver side and the
// command parser.
//   rx_data   : received byte, stable when rx_int falls
//   rx_int    : receiver busy flag, falling edge marks a completed byte
//   cfg_wr    : one-cycle strobe for a valid frame
//   cfg_addr  : ADDR of the last valid frame
//   cfg_wdata : {DHI,DLO} of the last valid frame
//   frame_err : one-cycle strobe on checksum mismatch or inter-byte timeout
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_int;
  logic        cfg_wr;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        frame_err;

  // Byte source side: drives the stream, observes the config results
  modport master (
    output rx_data, rx_int,
    input  cfg_wr, cfg_addr, cfg_wdata, frame_err
  );

  // Parser side
  modport slave (
    input  rx_data, rx_int,
    output cfg_wr, cfg_addr, cfg_wdata, frame_err
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames 5-byte host commands (HEADER, ADDR, DHI, DLO, CSUM) from the UART
// receiver byte stream, emits a config-write strobe for valid frames and keeps
// the oscilloscope shadow registers.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   bus          : rx byte stream in, cfg_wr/cfg_addr/cfg_wdata/frame_err out
//   trig_level   : trigger threshold        (addr 0x01, DLO)
//   timebase_div : sample-clock divider     (addr 0x02, {DHI,DLO})
//   run          : acquisition enable       (addr 0x03, DLO[0])
//   trig_edge    : 0 rising / 1 falling     (addr 0x03, DLO[1])
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_parser_if.slave   bus,
  output logic [7:0]         trig_level,
  output logic [15:0]        timebase_div,
  output logic               run,
  output logic               trig_edge
);

  localparam int unsigned    CNT_W    = 20;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_CSUM
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               rx_int_d;
  logic               byte_stb_c;
  logic               tmo_hit_c;
  logic               frame_ok_c;
  logic               frame_bad_c;
  logic [7:0]         addr_r;
  logic [7:0]         dhi_r;
  logic [7:0]         dlo_r;
  logic [CNT_W-1:0]   tmo_cnt;

  // Completed byte = falling edge of the receiver busy flag
  assign byte_stb_c = rx_int_d & ~bus.rx_int;

  // A byte arriving on the terminal count takes priority over the timeout
  assign tmo_hit_c = (state_q != S_IDLE) && !byte_stb_c && (tmo_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and frame verdict
  always_comb begin
    state_d     = state_q;
    frame_ok_c  = 1'b0;
    frame_bad_c = 1'b0;
    if (byte_stb_c) begin
      case (state_q)
        S_IDLE: if (bus.rx_data == HEADER) state_d = S_ADDR;
        S_ADDR: state_d = S_DHI;
        S_DHI:  state_d = S_DLO;
        S_DLO:  state_d = S_CSUM;
        S_CSUM: begin
          state_d = S_IDLE;
          if (bus.rx_data == (addr_r ^ dhi_r ^ dlo_r)) frame_ok_c  = 1'b1;
          else                                         frame_bad_c = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit_c) begin
      state_d = S_IDLE;
    end
  end

  // Byte capture, inter-byte timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_int_d      <= 1'b0;
      addr_r        <= 8'h00;
      dhi_r         <= 8'h00;
      dlo_r         <= 8'h00;
      tmo_cnt       <= '0;
      bus.cfg_wr    <= 1'b0;
      bus.cfg_addr  <= 8'h00;
      bus.cfg_wdata <= 16'h0000;
      bus.frame_err <= 1'b0;
      trig_level    <= 8'h80;
      timebase_div  <= 16'h0001;
      run           <= 1'b0;
      trig_edge     <= 1'b0;
    end else begin
      rx_int_d <= bus.rx_int;

      if (byte_stb_c) begin
        case (state_q)
          S_ADDR:  addr_r <= bus.rx_data;
          S_DHI:   dhi_r  <= bus.rx_data;
          S_DLO:   dlo_r  <= bus.rx_data;
          default: ;
        endcase
      end

      if (byte_stb_c || tmo_hit_c)  tmo_cnt <= '0;
      else if (state_q != S_IDLE)   tmo_cnt <= tmo_cnt + CNT_W'(1);

      bus.cfg_wr    <= frame_ok_c;
      bus.frame_err <= frame_bad_c | tmo_hit_c;

      // Unknown addresses still publish cfg_addr/cfg_wdata but touch no shadow
      if (frame_ok_c) begin
        bus.cfg_addr  <= addr_r;
        bus.cfg_wdata <= {dhi_r, dlo_r};
        case (addr_r)
          8'h01: trig_level   <= dlo_r;
          8'h02: timebase_div <= {dhi_r, dlo_r};
          8'h03: begin
            run       <= dlo_r[0];
            trig_edge <= dlo_r[1];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
